// File: rtl/s3g_tx.sv
// S3G packet transmitter.
// Frames the payload held in a 256x8 buffer as SYNC, LEN, payload[0..LEN-1], CRC8 and hands
// each byte to a byte-level UART through a send/ready handshake.
// Optional feature macro: S3G_TX_DUALPORT_EN. When defined, port_sel_i steers the packet to
// UART 2. When undefined, every packet goes to UART 1 and the UART 2 outputs stay at zero.
module s3g_tx #(
  parameter logic [7:0] SyncByte = 8'hD5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       start_i,
  input  logic [7:0] payload_len_i,
  input  logic       port_sel_i,
  output logic       busy_o,
  output logic       packet_sent_o,
  output logic [7:0] tx1_data_o,
  output logic       tx1_send_o,
  input  logic       tx1_ready_i,
  output logic [7:0] tx2_data_o,
  output logic       tx2_send_o,
  input  logic       tx2_ready_i
);

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StSyncGap,
    StLen,
    StFetch,
    StData,
    StCrcGap,
    StCrc,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] len_q, len_d;
  logic       port_q, port_d;
  logic [7:0] mem_q [256];

  logic       ready_sel;
  logic       send_state;
  logic       send;

  // Dallas/Maxim CRC-8 (reflected poly 8Ch), one data byte per call.
  function automatic logic [7:0] crc8_next(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Ready of whichever UART the current packet is bound to.
`ifdef S3G_TX_DUALPORT_EN
  always_comb begin
    ready_sel = port_q ? tx2_ready_i : tx1_ready_i;
  end
`else
  logic unused_dualport;
  assign unused_dualport = tx2_ready_i ^ port_sel_i;

  always_comb begin
    ready_sel = tx1_ready_i;
  end
`endif

  // Payload buffer: writable only while no packet is in flight; never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_o) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; every send state waits for ready, gap states follow a send that is not
  // already followed by a FETCH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StSync;
      StSync:    if (ready_sel) state_d = StSyncGap;
      StSyncGap: state_d = StLen;
      StLen: begin
        if (ready_sel) state_d = (len_q == 8'd0) ? StCrcGap : StFetch;
      end
      StFetch:   state_d = StData;
      StData: begin
        if (ready_sel) state_d = (cnt_q == 8'd1) ? StCrcGap : StFetch;
      end
      StCrcGap:  state_d = StCrc;
      StCrc:     if (ready_sel) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next state: the byte for each send state is loaded on entry so it is a register
  // output by the time the strobe can fire.
  always_comb begin
    tx_data_d = tx_data_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    len_d     = len_q;
    port_d    = port_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d     = payload_len_i;
          cnt_d     = payload_len_i;
          crc_d     = 8'd0;
          rd_addr_d = 8'd0;
          tx_data_d = SyncByte;
`ifdef S3G_TX_DUALPORT_EN
          port_d    = port_sel_i;
`else
          port_d    = 1'b0;
`endif
        end
      end
      StSyncGap: tx_data_d = len_q;
      StFetch:   tx_data_d = mem_q[rd_addr_q];
      StData: begin
        if (ready_sel) begin
          crc_d     = crc8_next(tx_data_q, crc_q);
          rd_addr_d = rd_addr_q + 8'd1;
          cnt_d     = cnt_q - 8'd1;
        end
      end
      StCrcGap:  tx_data_d = crc_q;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_data_q <= 8'd0;
      crc_q     <= 8'd0;
      cnt_q     <= 8'd0;
      rd_addr_q <= 8'd0;
      len_q     <= 8'd0;
      port_q    <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
      port_q    <= port_d;
    end
  end

  // FSM outputs; the strobe is gated by the live ready so it can only fire when accepted.
  always_comb begin
    send_state    = (state_q == StSync) || (state_q == StLen) ||
                    (state_q == StData) || (state_q == StCrc);
    send          = send_state && ready_sel;
    busy_o        = (state_q != StIdle);
    packet_sent_o = (state_q == StDone);
`ifdef S3G_TX_DUALPORT_EN
    tx1_send_o    = send && !port_q;
    tx2_send_o    = send && port_q;
    tx1_data_o    = port_q ? 8'd0 : tx_data_q;
    tx2_data_o    = port_q ? tx_data_q : 8'd0;
`else
    tx1_send_o    = send;
    tx2_send_o    = 1'b0;
    tx1_data_o    = tx_data_q;
    tx2_data_o    = 8'd0;
`endif
  end

endmodule
